fib_seq_gen: RTL and testbench
==============================

Name: fib_seq_gen

Overview:
- Parametrised Fibonacci-type sequence generator with seeds loaded at run time.
- On a start request, emits a programmable number of terms, one per accepted valid/ready handshake.
- Reports per-term and sticky arithmetic wrap, and signals busy/done.
- Sits behind a control register bank; feeds a downstream consumer stream such as a FIFO or display formatter.

Parameters:
- WIDTH, 32, bit width of seeds and of every emitted term; arithmetic is modulo 2^WIDTH.
- CNT_W, 8, bit width of the term-count request and of the term index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- seed0  input  WIDTH  first term; latched when start is accepted.
- seed1  input  WIDTH  second term; latched when start is accepted.
- num_terms  input  CNT_W  number of terms to emit; latched when start is accepted.
- out_valid  output  1  fib_out, term_idx and term_ovf are valid.
- out_ready  input  1  consumer accepts the current term.
- fib_out  output  WIDTH  current term.
- term_idx  output  CNT_W  index of the current term, counting from 0.
- term_ovf  output  1  current term has been affected by wrap, directly or inherited.
- ovf_sticky  output  1  some emitted term in this run had term_ovf=1; cleared when start is accepted.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; registers a, b, remaining and idx are 0; wrap flags are 0.
  - All outputs are 0.
  - Reset mid-run aborts the run immediately; no done pulse follows.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches a=seed0, b=seed1, remaining=num_terms, idx=0.
  - It also clears wrap_a, wrap_b and ovf_sticky.
  - Next state is RUN if num_terms!=0, otherwise DONE.
  - start in any other state is ignored; no re-latch.
- RUN:
  - out_valid=1 registered.
  - fib_out=a, term_idx=idx, term_ovf=wrap_a.
  - Outputs stay stable while out_ready=0.
- Handshake: on out_valid&&out_ready, all of the following update in the same cycle:
  - a<=b and wrap_a<=wrap_b.
  - b<=(a+b) mod 2^WIDTH.
  - wrap_b<=carry(a+b)|wrap_a|wrap_b, where carry is bit WIDTH of the WIDTH+1-bit sum.
  - ovf_sticky<=ovf_sticky|wrap_a.
  - idx<=idx+1 and remaining<=remaining-1.
  - If remaining==1, next state is DONE and out_valid drops the next cycle.
- Throughput: one term per cycle with out_ready held high. Latency: first term valid on the cycle after start.
- DONE: lasts exactly one cycle with done=1 and out_valid=0, then returns to IDLE.
- Outputs in IDLE and DONE:
  - fib_out and term_idx hold their last values and are don't-care for the consumer.
  - ovf_sticky holds until the next accepted start.
- num_terms=0: start -> DONE -> IDLE; no term is emitted.
- Maximum run is 2^CNT_W-1 terms; idx never wraps within a run.

Test Plan:
- Basic run: seeds 0,1, num_terms=10, out_ready=1 -> terms 0,1,1,2,3,5,8,13,21,34 on consecutive cycles with idx 0..9; done pulses one cycle after the last term; busy high from the cycle after start until done.
- Backpressure: same run with out_ready toggling 1,0,0,1,... -> identical term sequence; each term is held stable while out_ready=0; no term is lost or duplicated.
- Wrap at WIDTH=8: seeds 0,1, num_terms=16 -> idx13=233 with term_ovf=0; idx14=121 with term_ovf=1; idx15=98 with term_ovf=1; ovf_sticky=1 after done.
- Custom seeds and zero count: seeds 2,1, num_terms=5 -> 2,1,3,4,7. Then num_terms=0 -> done after one cycle with out_valid never asserted.
- Start while busy: start pulsed with new seeds during RUN -> ignored; the current sequence continues unchanged.
- Async reset: rst asserted mid-RUN between clock edges -> out_valid, busy and done drop immediately with no done pulse; a subsequent start runs correctly from the new seeds.

Source files
------------

// File: rtl/fib_seq_gen.sv
// Fibonacci-type sequence generator: run-time seeds, programmable term count,
// valid/ready output stream, per-term and sticky wrap reporting.
module fib_seq_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fib_out,
  output logic [CNT_W-1:0] term_idx,
  output logic             term_ovf,
  output logic             ovf_sticky,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a, b;
  logic             wrap_a, wrap_b;
  logic [CNT_W-1:0] remaining, idx;
  logic [WIDTH:0]   sum;
  logic             fire;
  logic             accept;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign fire   = (state == RUN) && out_ready;
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = (num_terms != '0) ? RUN : DONE;
      RUN:  if (fire && remaining == CNT_W'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wrap taint travels with the term: b's flag moves to a on every shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a          <= '0;
      b          <= '0;
      wrap_a     <= 1'b0;
      wrap_b     <= 1'b0;
      remaining  <= '0;
      idx        <= '0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      a          <= seed0;
      b          <= seed1;
      wrap_a     <= 1'b0;
      wrap_b     <= 1'b0;
      remaining  <= num_terms;
      idx        <= '0;
      ovf_sticky <= 1'b0;
    end else if (fire) begin
      a          <= b;
      wrap_a     <= wrap_b;
      b          <= sum[WIDTH-1:0];
      wrap_b     <= sum[WIDTH] | wrap_a | wrap_b;
      ovf_sticky <= ovf_sticky | wrap_a;
      idx        <= idx + CNT_W'(1);
      remaining  <= remaining - CNT_W'(1);
    end
  end

  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fib_out   = a;
  assign term_idx  = idx;
  assign term_ovf  = wrap_a;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed self-checking bench for fib_seq_gen (32-bit instance plus an 8-bit
// instance for wrap behaviour).
module tb_fib_seq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed0 = '0, seed1 = '0;
  logic [7:0]  num_terms = '0;
  logic        out_ready = 1'b1;
  logic        out_valid, term_ovf, ovf_sticky, busy, done;
  logic [31:0] fib_out;
  logic [7:0]  term_idx;

  logic        start8 = 1'b0;
  logic [7:0]  seed0_8 = '0, seed1_8 = '0, num8 = '0;
  logic        out_valid8, term_ovf8, ovf_sticky8, busy8, done8;
  logic [7:0]  fib_out8, term_idx8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
    .num_terms(num_terms), .out_valid(out_valid), .out_ready(out_ready),
    .fib_out(fib_out), .term_idx(term_idx), .term_ovf(term_ovf),
    .ovf_sticky(ovf_sticky), .busy(busy), .done(done)
  );

  fib_seq_gen #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .seed0(seed0_8), .seed1(seed1_8),
    .num_terms(num8), .out_valid(out_valid8), .out_ready(out_ready),
    .fib_out(fib_out8), .term_idx(term_idx8), .term_ovf(term_ovf8),
    .ovf_sticky(ovf_sticky8), .busy(busy8), .done(done8)
  );

  task automatic launch(input logic [31:0] s0, input logic [31:0] s1, input logic [7:0] n);
    @(negedge clk);
    seed0 = s0; seed1 = s1; num_terms = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({out_valid, busy, done, term_ovf, ovf_sticky} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {out_valid, busy, done, term_ovf, ovf_sticky});
    end
    checks++;
    if (fib_out !== 32'd0 || term_idx !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: got fib=%0d idx=%0d expected 0 0", fib_out, term_idx);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] exp_t [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    out_ready = 1'b1;
    launch(32'd0, 32'd1, 8'd10);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          fib_out !== exp_t[i] || term_idx !== 8'(i)) begin
        errors++;
        $display("FAIL basic_term%0d: got v=%b b=%b d=%b fib=%0d idx=%0d expected v=1 b=1 d=0 fib=%0d idx=%0d",
                 i, out_valid, busy, done, fib_out, term_idx, exp_t[i], i);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: got d=%b v=%b b=%b expected 1 0 1", done, out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got d=%b b=%b sticky=%b expected 0 0 0", done, busy, ovf_sticky);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_t [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    logic [3:0]  pat = 4'b1001;
    int k = 0;
    bit saw_done = 0;
    launch(32'd0, 32'd1, 8'd10);
    for (int c = 0; c < 80; c++) begin
      out_ready = pat[3 - (c % 4)];
      if (done) begin saw_done = 1; break; end
      checks++;
      if (out_valid !== 1'b1 || k > 9 || fib_out !== exp_t[k % 10] || term_idx !== 8'(k)) begin
        errors++;
        $display("FAIL bp_cycle%0d: got v=%b fib=%0d idx=%0d expected v=1 fib=%0d idx=%0d",
                 c, out_valid, fib_out, term_idx, exp_t[k % 10], k);
      end
      if (out_ready) k++;
      @(negedge clk);
    end
    checks++;
    if (!saw_done || k !== 10) begin
      errors++;
      $display("FAIL bp_count: got done_seen=%0d terms=%0d expected 1 10", saw_done, k);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_custom_and_zero;
    logic [31:0] exp_t [5] = '{2, 1, 3, 4, 7};
    launch(32'd2, 32'd1, 8'd5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || fib_out !== exp_t[i] || term_idx !== 8'(i)) begin
        errors++;
        $display("FAIL custom_term%0d: got v=%b fib=%0d idx=%0d expected 1 %0d %0d",
                 i, out_valid, fib_out, term_idx, exp_t[i], i);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL custom_done: got d=%b v=%b expected 1 0", done, out_valid);
    end
    @(negedge clk);
    launch(32'd7, 32'd7, 8'd0);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: got d=%b v=%b b=%b expected 1 0 1", done, out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got d=%b v=%b b=%b expected 0 0 0", done, out_valid, busy);
    end
  endtask

  task automatic test_start_while_busy;
    logic [31:0] exp_t [6] = '{0, 1, 1, 2, 3, 5};
    launch(32'd0, 32'd1, 8'd6);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin seed0 = 32'd9; seed1 = 32'd9; num_terms = 8'd3; start = 1'b1; end
      if (i == 3) start = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || fib_out !== exp_t[i] || term_idx !== 8'(i)) begin
        errors++;
        $display("FAIL busy_start_term%0d: got v=%b fib=%0d idx=%0d expected 1 %0d %0d",
                 i, out_valid, fib_out, term_idx, exp_t[i], i);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_done: got d=%b expected 1", done);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_norerun: got v=%b b=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_wrap8;
    logic [7:0] exp_t [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    @(negedge clk);
    seed0_8 = 8'd0; seed1_8 = 8'd1; num8 = 8'd16; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid8 !== 1'b1 || fib_out8 !== exp_t[i] || term_idx8 !== 8'(i) ||
          term_ovf8 !== (i >= 14)) begin
        errors++;
        $display("FAIL wrap_term%0d: got v=%b fib=%0d idx=%0d ovf=%b expected 1 %0d %0d %0d",
                 i, out_valid8, fib_out8, term_idx8, term_ovf8, exp_t[i], i, (i >= 14));
      end
      @(negedge clk);
    end
    checks++;
    if (done8 !== 1'b1 || ovf_sticky8 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky: got d=%b sticky=%b expected 1 1", done8, ovf_sticky8);
    end
    @(negedge clk);
    checks++;
    if (ovf_sticky8 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky_hold: got %b expected 1", ovf_sticky8);
    end
    seed0_8 = 8'd3; seed1_8 = 8'd4; num8 = 8'd2; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (ovf_sticky8 !== 1'b0 || out_valid8 !== 1'b1 || fib_out8 !== 8'd3 || term_ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_restart: got sticky=%b v=%b fib=%0d ovf=%b expected 0 1 3 0",
               ovf_sticky8, out_valid8, fib_out8, term_ovf8);
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [31:0] exp_t [3] = '{5, 7, 12};
    launch(32'd0, 32'd1, 8'd10);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: got v=%b b=%b d=%b expected 0 0 0", out_valid, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_nodone: got d=%b b=%b expected 0 0", done, busy);
    end
    launch(32'd5, 32'd7, 8'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || fib_out !== exp_t[i] || term_idx !== 8'(i)) begin
        errors++;
        $display("FAIL areset_rerun%0d: got v=%b fib=%0d idx=%0d expected 1 %0d %0d",
                 i, out_valid, fib_out, term_idx, exp_t[i], i);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL areset_rerun_done: got d=%b expected 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_custom_and_zero();
    test_start_while_busy();
    test_wrap8();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
